// File: rtl/led_ctrl_if.sv
// Data-memory bus slice seen by the LED peripheral: decoder select, strobes,
// write data, and the peripheral's ack/read-back response.
interface led_ctrl_if;
  logic        cs_led;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cs_led, output we, output re, output wdata,
                  input  rdata, input ack);
  modport slave  (input  cs_led, input we, input re, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/led_ctrl.sv
// Memory-mapped LED peripheral: one control word (pattern/mask/half-period),
// a prescaled blink timer, and a two-state ack FSM on the data bus.
module led_ctrl #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  led_ctrl_if.slave  bus,
  output logic [7:0] leds
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    half_q, half_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    per_q, per_d;
  logic          phase_q, phase_d;

  logic        req, wr_en, tick, ack_o;
  logic [31:0] rdata_o;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^bus.wdata[31:24];
  assign req   = bus.cs_led & (bus.we | bus.re);
  assign wr_en = (state_q == S_IDLE) & req & bus.we;
  assign tick  = (half_q != 8'd0) && (pre_q == PRE_MAX);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: ACK always lasts one cycle, inputs ignored there
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; read-back is built from registered state only
  always_comb begin
    ack_o   = (state_q == S_ACK);
    rdata_o = '0;
    if (ack_o) rdata_o = {phase_q, 7'b0, half_q, mask_q, pattern_q};
  end

  assign bus.ack   = ack_o;
  assign bus.rdata = rdata_o;

  // Control word and blink timer; a write restarts the timer even on a tick
  always_comb begin
    pattern_d = pattern_q;
    mask_d    = mask_q;
    half_d    = half_q;
    pre_d     = pre_q;
    per_d     = per_q;
    phase_d   = phase_q;
    if (wr_en) begin
      pattern_d = bus.wdata[7:0];
      mask_d    = bus.wdata[15:8];
      half_d    = bus.wdata[23:16];
      pre_d     = '0;
      per_d     = 8'd0;
      phase_d   = 1'b0;
    end else if (half_q == 8'd0) begin
      pre_d   = '0;
      per_d   = 8'd0;
      phase_d = 1'b0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (per_q == half_q - 8'd1) begin
          per_d   = 8'd0;
          phase_d = ~phase_q;
        end else begin
          per_d = per_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= 8'd0;
      mask_q    <= 8'd0;
      half_q    <= 8'd0;
      pre_q     <= '0;
      per_q     <= 8'd0;
      phase_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      half_q    <= half_d;
      pre_q     <= pre_d;
      per_q     <= per_d;
      phase_q   <= phase_d;
    end
  end

  assign leds = pattern_q & ~(mask_q & {8{phase_q}});
endmodule
